// File: rtl/adder_seq_pkg.sv
// Shared constants and FSM state encoding for the word-serial adder.
package adder_seq_pkg;

  localparam int SLICE_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/adder.sv
// 6-bit combinational adder: s = x + y, with the carry in s[6].
module adder
  import adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic [SLICE_W:0]   s
);

  assign s = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/adder_word_seq.sv
// Wide adder built from one shared 6-bit adder.
// Each slice takes two passes: ADD sums the operand slices, and INC folds in
// the carry coming from the slice below.
module adder_word_seq
  import adder_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [SLICE_W-1:0] partial_q, partial_d;
  logic               carry_q, carry_d;
  logic               c1_q, c1_d;

  logic [SLICE_W-1:0] add_x, add_y;
  logic [SLICE_W:0]   add_s;

  // Adder input mux: the operand slices in ADD, the partial sum plus carry in INC.
  always_comb begin
    add_x = a_q[idx_q*SLICE_W +: SLICE_W];
    add_y = b_q[idx_q*SLICE_W +: SLICE_W];
    if (state_q == INC) begin
      add_x = partial_q;
      add_y = {{(SLICE_W-1){1'b0}}, carry_q};
    end
  end

  adder u_adder (
    .x (add_x),
    .y (add_y),
    .s (add_s)
  );

  // Next state for the FSM and the datapath registers.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    partial_d = partial_q;
    carry_d   = carry_q;
    c1_d      = c1_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        partial_d = add_s[SLICE_W-1:0];
        c1_d      = add_s[SLICE_W];
        state_d   = INC;
      end
      INC: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = add_s[SLICE_W-1:0];
        // At most one of the two passes can carry, so OR merges them.
        carry_d = c1_q | add_s[SLICE_W];
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      partial_q <= '0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      partial_q <= partial_d;
      carry_q   <= carry_d;
      c1_q      <= c1_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_adder_word_seq.sv
module tb_adder_word_seq;
  localparam int WORDS = 4;
  localparam int W     = 6 * WORDS;
  localparam int LAT   = 2 * WORDS;
  localparam int NSOAK = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_word_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Reference: the plain arithmetic sum, carry-out in the top bit.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Issue one operation from IDLE and wait for out_valid; leaves DONE pending.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W-1:0] so, output logic co, output int lat);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    so = sum; co = cout;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum !== '0)         begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] s;
    logic         c;
    logic [W:0]   e;
    int           lat;
    va[0] = 24'h123456; vb[0] = 24'h654321; vc[0] = 1'b0;
    va[1] = 24'hFFFFFF; vb[1] = 24'h000001; vc[1] = 1'b0;
    va[2] = 24'hFFFFFF; vb[2] = 24'hFFFFFF; vc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = model(va[i], vb[i], vc[i]);
      run_op(va[i], vb[i], vc[i], s, c, lat);
      checks++; if (lat !== LAT)   begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (s !== e[W-1:0]) begin errors++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, e[W-1:0]); end
      checks++; if (c !== e[W])    begin errors++; $display("FAIL dir%0d_cout got=%b exp=%b", i, c, e[W]); end
      release_result();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_idle got=%b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s, av, bv;
    logic         c, cv;
    logic [W:0]   e;
    int           lat;
    av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
    e  = model(av, bv, cv);
    run_op(av, bv, cv, s, c, lat);
    checks++; if (s !== e[W-1:0] || c !== e[W]) begin errors++; $display("FAIL bp_result got=%b_%h exp=%b_%h", c, s, e[W], e[W-1:0]); end
    in_valid = 1'b1; a = ~av; b = ~bv; cin = ~cv;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== e[W-1:0] || cout !== e[W] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b s=%h c=%b rdy=%b exp v=1 s=%h c=%b rdy=0",
                 i, out_valid, sum, cout, in_ready, e[W-1:0], e[W]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    a = 24'hABCDEF; b = 24'h13579B; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== '0)         begin errors++; $display("FAIL mid_sum got=%h exp=0", sum); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(24'h000001, 24'h000002, 1'b0, s, c, lat);
    checks++; if (s !== 24'h000003 || c !== 1'b0) begin errors++; $display("FAIL mid_after got=%b_%h exp=0_000003", c, s); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL mid_after_latency got=%0d exp=%0d", lat, LAT); end
    release_result();
  endtask

  task automatic test_soak();
    logic [W:0] exp_q[$];
    int         got = 0;
    fork
      begin : producer
        for (int n = 0; n < NSOAK; n++) begin
          logic [W-1:0] av, bv;
          logic         cv, rdy;
          int           wait_cyc;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
          a = av; b = bv; cin = cv; in_valid = 1'b1;
          wait_cyc = 0;
          do begin
            rdy = in_ready;
            @(posedge clk); #1;
            wait_cyc++;
          end while (!rdy && wait_cyc < 1000);
          in_valid = 1'b0;
          if (!rdy) begin
            errors++; checks++;
            $display("FAIL soak_accept_timeout op=%0d", n);
            break;
          end
          exp_q.push_back(model(av, bv, cv));
        end
      end
      begin : consumer
        int cyc = 0;
        while (got < NSOAK && cyc < 60000) begin
          logic         v, r, c;
          logic [W-1:0] s;
          logic [W:0]   e;
          out_ready = 1'($urandom_range(0, 1));
          v = out_valid; r = out_ready; s = sum; c = cout;
          @(posedge clk); #1;
          cyc++;
          if (v && r) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL soak_unexpected_result got=%b_%h", c, s);
            end else begin
              e = exp_q.pop_front();
              if (s !== e[W-1:0] || c !== e[W]) begin
                errors++;
                $display("FAIL soak_result%0d got=%b_%h exp=%b_%h", got, c, s, e[W], e[W-1:0]);
              end
            end
            got++;
          end
        end
        out_ready = 1'b0;
      end
    join
    checks++; if (got !== NSOAK) begin errors++; $display("FAIL soak_count got=%0d exp=%0d", got, NSOAK); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL soak_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
